// File: rtl/reg_operand_fetch.sv
// Operand-fetch stage in front of a 2-read/1-write register file.
// S1 issues the synchronous reads and captures same-cycle writebacks.
// S2 is the output register; it absorbs writebacks while stalled.
// Optional build macro: ZERO_REG_EN (register 0 reads as zero, never forwarded).
module reg_operand_fetch #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned TAG_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_reg_a,
    input  logic [ADDR_WIDTH-1:0] in_reg_b,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic [ADDR_WIDTH-1:0] rf_addr_r_a,
    output logic [ADDR_WIDTH-1:0] rf_addr_r_b,
    input  logic [DATA_WIDTH-1:0] rf_data_a,
    input  logic [DATA_WIDTH-1:0] rf_data_b,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [DATA_WIDTH-1:0] out_data_a,
    output logic [DATA_WIDTH-1:0] out_data_b
);

    // S1: read issued, data arriving next cycle
    logic                  r_s1_valid;
    logic [ADDR_WIDTH-1:0] r_s1_reg_a;
    logic [ADDR_WIDTH-1:0] r_s1_reg_b;
    logic [TAG_WIDTH-1:0]  r_s1_tag;
    logic                  r_s1_fwd_a;
    logic                  r_s1_fwd_b;
    logic [DATA_WIDTH-1:0] r_s1_fwd_data_a;
    logic [DATA_WIDTH-1:0] r_s1_fwd_data_b;

    // S2: output register
    logic                  r_out_valid;
    logic [TAG_WIDTH-1:0]  r_out_tag;
    logic [DATA_WIDTH-1:0] r_out_data_a;
    logic [DATA_WIDTH-1:0] r_out_data_b;
    logic [ADDR_WIDTH-1:0] r_s2_reg_a;
    logic [ADDR_WIDTH-1:0] r_s2_reg_b;

    logic                  w_s2_free;
    logic                  w_accept;
    logic                  w_s1_advance;
    logic                  w_s2_hold;
    logic                  w_wb_ok;
    logic [DATA_WIDTH-1:0] w_s1_op_a;
    logic [DATA_WIDTH-1:0] w_s1_op_b;
    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_op_b;

    assign w_s2_free    = !r_out_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s2_free;
    assign w_accept     = in_valid && in_ready;
    assign w_s1_advance = r_s1_valid && w_s2_free;
    assign w_s2_hold    = r_out_valid && !out_ready;

    // A held S1 re-issues its own read every cycle so the data tracks the RF.
    assign rf_addr_r_a = w_accept ? in_reg_a : r_s1_reg_a;
    assign rf_addr_r_b = w_accept ? in_reg_b : r_s1_reg_b;

    // The RF returns old data on a same-cycle write, so the forward wins.
    assign w_s1_op_a = r_s1_fwd_a ? r_s1_fwd_data_a : rf_data_a;
    assign w_s1_op_b = r_s1_fwd_b ? r_s1_fwd_data_b : rf_data_b;

`ifdef ZERO_REG_EN
    // Writes to register 0 never match anything.
    assign w_wb_ok = wb_we && (wb_addr != '0);
    assign w_op_a  = (r_s1_reg_a == '0) ? '0 : w_s1_op_a;
    assign w_op_b  = (r_s1_reg_b == '0) ? '0 : w_s1_op_b;
`else
    assign w_wb_ok = wb_we;
    assign w_op_a  = w_s1_op_a;
    assign w_op_b  = w_s1_op_b;
`endif

    assign out_valid  = r_out_valid;
    assign out_tag    = r_out_tag;
    assign out_data_a = r_out_data_a;
    assign out_data_b = r_out_data_b;

    // S1 occupancy and captured instruction fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_reg_a <= '0;
            r_s1_reg_b <= '0;
            r_s1_tag   <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_reg_a <= in_reg_a;
            r_s1_reg_b <= in_reg_b;
            r_s1_tag   <= in_tag;
        end else if (w_s1_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Capture a writeback that hits the address driven this cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_fwd_a      <= 1'b0;
            r_s1_fwd_b      <= 1'b0;
            r_s1_fwd_data_a <= '0;
            r_s1_fwd_data_b <= '0;
        end else begin
            r_s1_fwd_a <= w_wb_ok && (wb_addr == rf_addr_r_a);
            r_s1_fwd_b <= w_wb_ok && (wb_addr == rf_addr_r_b);
            if (w_wb_ok && (wb_addr == rf_addr_r_a)) begin
                r_s1_fwd_data_a <= wb_data;
            end
            if (w_wb_ok && (wb_addr == rf_addr_r_b)) begin
                r_s1_fwd_data_b <= wb_data;
            end
        end
    end

    // S2 load from S1, handshake retire, and writeback update while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_tag    <= '0;
            r_out_data_a <= '0;
            r_out_data_b <= '0;
            r_s2_reg_a   <= '0;
            r_s2_reg_b   <= '0;
        end else if (w_s1_advance) begin
            r_out_valid  <= 1'b1;
            r_out_tag    <= r_s1_tag;
            r_out_data_a <= w_op_a;
            r_out_data_b <= w_op_b;
            r_s2_reg_a   <= r_s1_reg_a;
            r_s2_reg_b   <= r_s1_reg_b;
        end else if (w_s2_hold) begin
            if (w_wb_ok && (wb_addr == r_s2_reg_a)) begin
                r_out_data_a <= wb_data;
            end
            if (w_wb_ok && (wb_addr == r_s2_reg_b)) begin
                r_out_data_b <= wb_data;
            end
        end else if (r_out_valid) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Bench for reg_operand_fetch: register-file model, scoreboard queue filled at
// issue time, and a monitor that pops on every output handshake.
module tb_reg_operand_fetch;

    typedef struct packed {
        logic [15:0] tag;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_reg_a;
    logic [3:0]  in_reg_b;
    logic [15:0] in_tag;
    logic [3:0]  rf_addr_r_a;
    logic [3:0]  rf_addr_r_b;
    logic [15:0] rf_data_a;
    logic [15:0] rf_data_b;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_tag;
    logic [15:0] out_data_a;
    logic [15:0] out_data_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   run      = 0;
    int   max_run  = 0;
    logic done;
    exp_t sb[$];

    logic [15:0] rf [16] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h1234,
                             16'h0404, 16'h00FF, 16'h0000, 16'h0700,
                             16'hA008, 16'hA009, 16'hA00A, 16'hA00B,
                             16'hA00C, 16'hA00D, 16'hA00E, 16'hA00F};

    // Expected operands for regs 8..15 and 15..8
    logic [15:0] t_up [8] = '{16'hA008, 16'hA009, 16'hA00A, 16'hA00B,
                              16'hA00C, 16'hA00D, 16'hA00E, 16'hA00F};
    logic [15:0] t_dn [8] = '{16'hA00F, 16'hA00E, 16'hA00D, 16'hA00C,
                              16'hA00B, 16'hA00A, 16'hA009, 16'hA008};

    reg_operand_fetch #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(4),
        .TAG_WIDTH (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_reg_a   (in_reg_a),
        .in_reg_b   (in_reg_b),
        .in_tag     (in_tag),
        .rf_addr_r_a(rf_addr_r_a),
        .rf_addr_r_b(rf_addr_r_b),
        .rf_data_a  (rf_data_a),
        .rf_data_b  (rf_data_b),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tag    (out_tag),
        .out_data_a (out_data_a),
        .out_data_b (out_data_b)
    );

    always #5 clk = ~clk;

    // Register file: 1-cycle synchronous read, read-during-write returns old data
    always @(posedge clk) begin
        rf_data_a <= rf[rf_addr_r_a];
        rf_data_b <= rf[rf_addr_r_b];
        if (wb_we) rf[wb_addr] <= wb_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one instruction until accepted; expected result queued up front.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [15:0] tag,
                        input logic [15:0] ea, input logic [15:0] eb);
        int   waited;
        logic acc;
        sb.push_back(exp_t'{tag: tag, a: ea, b: eb});
        in_valid = 1'b1;
        in_reg_a = a;
        in_reg_b = b;
        in_tag   = tag;
        waited   = 0;
        acc      = 1'b0;
        while (!acc && waited < 50) begin
            #1;
            acc = in_ready;
            tick();
            waited++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'(acc), 32'h1);
    endtask

    // Monitor: every output handshake pops and compares one expected entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                run = 0;
            end else if (out_valid && out_ready) begin
                run++;
                if (run > max_run) max_run = run;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got tag 0x%0h, expected none", out_tag);
                end else begin
                    e = sb.pop_front();
                    check("out_tag", 32'(out_tag), 32'(e.tag));
                    check("out_data_a", 32'(out_data_a), 32'(e.a));
                    check("out_data_b", 32'(out_data_b), 32'(e.b));
                end
            end else begin
                run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] zero_exp;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_reg_a  = '0;
        in_reg_b  = '0;
        in_tag    = '0;
        wb_we     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        out_ready = 1'b0;
        done      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_tag", 32'(out_tag), 32'h0);
        check("rst_out_data_a", 32'(out_data_a), 32'h0);
        check("rst_out_data_b", 32'(out_data_b), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        tick();
        reset_n = 1'b1;
        tick();

        // Basic read and 2-cycle latency
        out_ready = 1'b1;
        send(4'd3, 4'd5, 16'h0001, 16'h1234, 16'h00FF);
        @(negedge clk);
        check("lat_cycle1_valid", 32'(out_valid), 32'h0);
        tick();
        @(negedge clk);
        check("lat_cycle2_valid", 32'(out_valid), 32'h1);
        check("lat_data_a", 32'(out_data_a), 32'h1234);
        tick();
        tick();

        // Same-cycle writeback forward, a == b
        wb_we   = 1'b1;
        wb_addr = 4'd2;
        wb_data = 16'hBEEF;
        send(4'd2, 4'd2, 16'h0002, 16'hBEEF, 16'hBEEF);
        wb_we = 1'b0;
        repeat (3) tick();

        // Register 0 behaviour
`ifdef ZERO_REG_EN
        zero_exp = 16'h0000;
`else
        zero_exp = 16'h1111;
`endif
        wb_we   = 1'b1;
        wb_addr = 4'd0;
        wb_data = 16'h1111;
        send(4'd0, 4'd3, 16'h0040, zero_exp, 16'h1234);
        wb_we = 1'b0;
        repeat (3) tick();

        // S2 held: writeback updates the stalled operand
        out_ready = 1'b0;
        send(4'd4, 4'd3, 16'h0003, 16'h5A5A, 16'h1234);
        tick();
        wb_we   = 1'b1;
        wb_addr = 4'd4;
        wb_data = 16'h5A5A;
        @(negedge clk);
        check("hold_valid", 32'(out_valid), 32'h1);
        check("hold_pre_a", 32'(out_data_a), 32'h0404);
        tick();
        wb_we     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_post_a", 32'(out_data_a), 32'h5A5A);
        check("hold_post_b", 32'(out_data_b), 32'h1234);
        tick();
        @(negedge clk);
        check("hold_single_xfer", 32'(out_valid), 32'h0);
        tick();

        // S2 stalled, S1 full and re-issuing; forward caught in S1
        out_ready = 1'b0;
        send(4'd3, 4'd5, 16'h0004, 16'h1234, 16'h00FF);
        send(4'd7, 4'd3, 16'h0005, 16'h7777, 16'h1234);
        wb_we   = 1'b1;
        wb_addr = 4'd7;
        wb_data = 16'h7777;
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'h0);
        check("full_reissue_addr", 32'(rf_addr_r_a), 32'h7);
        tick();
        wb_we     = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        // Back-to-back with out_ready high: no bubbles
        run     = 0;
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            send(4'(8 + i), 4'(15 - i), 16'(16'h0010 + i), t_up[i], t_dn[i]);
        end
        repeat (4) tick();
        check("b2b_run_length", 32'(max_run), 32'd8);

        // Random backpressure: no loss or duplication
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(4'(8 + i), 4'(8 + i), 16'(16'h0020 + i), t_up[i], t_up[i]);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) tick();
        check("rand_drain_empty", 32'(sb.size()), 32'h0);
        tick();

        // Reset asserted during a stall
        out_ready = 1'b0;
        send(4'd3, 4'd5, 16'h0030, 16'h1234, 16'h00FF);
        tick();
        @(negedge clk);
        check("stall_valid", 32'(out_valid), 32'h1);
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_out_tag", 32'(out_tag), 32'h0);
        check("midrst_out_data_a", 32'(out_data_a), 32'h0);
        check("midrst_out_data_b", 32'(out_data_b), 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'h1);
        sb.delete();
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
